// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer: serialises RV32I loads/stores into little-endian byte transactions
module lsu_byte_sequencer #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic          resp_err,
  output logic [DW-1:0] resp_rdata,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0] funct3_q, funct3_d;
  logic write_q, write_d, err_q, err_d;
  logic [DW-1:0] wdata_q, wdata_d, buf_q, buf_d, rdata_q, rdata_d;
  logic [1:0] last, cnt_m1;
  logic accept, req_err, xfer;
  logic [DW-1:0] full, ext;
  always_comb begin
    last = {funct3_q[1], funct3_q[1] | funct3_q[0]};
    cnt_m1 = cnt_q - 2'd1;
    accept = req_valid && req_ready;
    req_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_write && req_funct3[2]) ||
              (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    full = buf_q;
    full[{last, 3'b000} +: 8] = mem_rdata;
    ext = funct3_q[1] ? full :
          funct3_q[0] ? {{16{~funct3_q[2] & full[15]}}, full[15:0]} :
                        {{24{~funct3_q[2] & full[7]}}, full[7:0]};
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    funct3_d = funct3_q;
    write_d = write_q;
    wdata_d = wdata_q;
    err_d = err_q;
    buf_d = buf_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d = req_addr;
        funct3_d = req_funct3;
        write_d = req_write;
        wdata_d = req_wdata;
        cnt_d = '0;
        err_d = req_err;
        state_d = req_err ? RESP : XFER;
        rdata_d = req_err ? '0 : rdata_q;
      end
      XFER: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q != 2'd0) buf_d[{cnt_m1, 3'b000} +: 8] = mem_rdata;
        if (cnt_q == last) begin
          state_d = write_q ? RESP : DRAIN;
          rdata_d = write_q ? '0 : rdata_q;
        end
      end
      DRAIN: begin
        buf_d = full;
        rdata_d = ext;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      funct3_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q <= 1'b0;
      buf_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      funct3_q <= funct3_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      buf_q <= buf_d;
      rdata_q <= rdata_d;
    end
  end
  // Outputs are gated by rst so an aborted store stops writing in the reset cycle itself
  always_comb begin
    xfer = (state_q == XFER) && !rst;
    req_ready = (state_q == IDLE) && !rst;
    resp_valid = (state_q == RESP) && !rst;
    resp_err = resp_valid && err_q;
    resp_rdata = rst ? '0 : rdata_q;
    mem_address = xfer ? addr_q + AW'(cnt_q) : '0;
    mem_read = xfer && !write_q;
    mem_write = xfer && write_q;
    mem_wdata = mem_write ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
  end
endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb_lsu_byte_sequencer: directed and randomized checks against a byte-array memory model
module tb_lsu_byte_sequencer;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_write = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_address;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int checks = 0, passed = 0;

  lsu_byte_sequencer #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:0]] <= mem_wdata;
    mem_rdata <= mem_read ? mem[mem_address[7:0]] : 8'h00;
  end

  function automatic int size_of(logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic is_err(logic w, logic [2:0] f3, logic [31:0] a);
    int n = size_of(f3);
    return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (w && f3 >= 3'd4) || (a % n != 0);
  endfunction

  function automatic logic [31:0] load_model(logic [2:0] f3, logic [31:0] a);
    int n = size_of(f3);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) & 255]) << (8 * i);
    if (f3 < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd,
                         output int nrd, output int nwr, output logic bad);
    int waited = 0;
    lat = -1; err = 1'b0; rd = '0; nrd = 0; nwr = 0; bad = 1'b0;
    while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_read && mem_write) bad = 1'b1;
      if (mem_read) begin
        if (mem_address !== a + nrd) bad = 1'b1;
        nrd++;
      end
      if (mem_write) begin
        if (mem_address !== a + nwr || nwr > 3 || mem_wdata !== wd[8 * (nwr & 3) +: 8]) bad = 1'b1;
        nwr++;
      end
      if (resp_valid) begin lat = k; err = resp_err; rd = resp_rdata; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", req_ready); else passed++;
    checks++; if ({resp_valid, resp_err, resp_rdata} !== 34'd0) $display("FAIL reset_resp got %b/%b/%h exp 0", resp_valid, resp_err, resp_rdata); else passed++;
    checks++; if ({mem_read, mem_write, mem_address, mem_wdata} !== 42'd0) $display("FAIL reset_mem got %b/%b/%h/%h exp 0", mem_read, mem_write, mem_address, mem_wdata); else passed++;
    rst = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", req_ready); else passed++;
  endtask

  task automatic test_directed;
    int lat, nrd, nwr; logic err, bad; logic [31:0] rd;
    logic [2:0] f3s [6] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
    logic [31:0] adrs [6] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [31:0] exps [6] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFEF};
    int lats [6] = '{6, 3, 3, 4, 4, 3};
    int nrds [6] = '{4, 1, 1, 2, 2, 1};
    run_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, lat, err, rd, nrd, nwr, bad);
    checks++; if (lat !== 5) $display("FAIL sw_latency got %0d exp 5", lat); else passed++;
    checks++; if ({err, rd} !== 33'd0) $display("FAIL sw_resp got err=%b rdata=%h exp 0/0", err, rd); else passed++;
    checks++; if (nwr !== 4 || nrd !== 0 || bad) $display("FAIL sw_strobes got wr=%0d rd=%0d bad=%b exp 4/0/0", nwr, nrd, bad); else passed++;
    checks++; if ({mem[19], mem[18], mem[17], mem[16]} !== 32'hDEADBEEF) $display("FAIL sw_memory got %h exp deadbeef", {mem[19], mem[18], mem[17], mem[16]}); else passed++;
    for (int i = 0; i < 6; i++) begin
      run_req(1'b0, f3s[i], adrs[i], $urandom, lat, err, rd, nrd, nwr, bad);
      checks++; if (rd !== exps[i] || err !== 1'b0) $display("FAIL load%0d_data got %h err=%b exp %h err=0", i, rd, err, exps[i]); else passed++;
      checks++; if (lat !== lats[i]) $display("FAIL load%0d_latency got %0d exp %0d", i, lat, lats[i]); else passed++;
      checks++; if (nrd !== nrds[i] || nwr !== 0 || bad) $display("FAIL load%0d_strobes got rd=%0d wr=%0d bad=%b exp %0d/0/0", i, nrd, nwr, bad, nrds[i]); else passed++;
    end
  endtask

  task automatic test_errors;
    int lat, nrd, nwr; logic err, bad; logic [31:0] rd;
    logic ws [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0] f3s [3] = '{3'd2, 3'd1, 3'd3};
    logic [31:0] adrs [3] = '{32'h11, 32'h13, 32'h10};
    for (int i = 0; i < 3; i++) begin
      run_req(ws[i], f3s[i], adrs[i], 32'hFFFFFFFF, lat, err, rd, nrd, nwr, bad);
      checks++; if (lat !== 1 || err !== 1'b1) $display("FAIL err%0d_resp got lat=%0d err=%b exp 1/1", i, lat, err); else passed++;
      checks++; if (rd !== 32'd0 || nrd !== 0 || nwr !== 0) $display("FAIL err%0d_quiet got rdata=%h rd=%0d wr=%0d exp 0/0/0", i, rd, nrd, nwr); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    int lat, nrd, nwr; logic err, bad, seen_resp; logic [31:0] rd;
    run_req(1'b1, 3'd2, 32'h20, 32'h0, lat, err, rd, nrd, nwr, bad);
    seen_resp = 1'b0;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b0;
    seen_resp |= resp_valid;
    @(negedge clk);
    seen_resp |= resp_valid;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if ({req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_address, mem_wdata} !== 77'd0)
      $display("FAIL midrst_outputs got ready=%b rv=%b err=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h exp all 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_address, mem_wdata); else passed++;
    @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL midrst_ready got %b exp 1", req_ready); else passed++;
    for (int k = 0; k < 8; k++) begin @(negedge clk); seen_resp |= resp_valid; end
    checks++; if (seen_resp !== 1'b0) $display("FAIL midrst_no_resp got %b exp 0", seen_resp); else passed++;
    checks++; if ({mem[35], mem[34], mem[33], mem[32]} !== 32'h00003344) $display("FAIL midrst_memory got %h exp 00003344", {mem[35], mem[34], mem[33], mem[32]}); else passed++;
  endtask

  task automatic test_back_to_back;
    int acc = -1, r1 = -1, r2 = -1;
    logic [31:0] rd = '0;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h30; req_wdata = 32'h000000A5;
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'd4; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) @(negedge clk);
      if (acc >= 0 && k == acc + 1) req_valid = 1'b0;
      if (resp_valid && r1 < 0) r1 = k;
      else if (resp_valid && r2 < 0) begin r2 = k; rd = resp_rdata; end
      if (req_valid && req_ready && acc < 0) acc = k;
    end
    req_valid = 1'b0;
    checks++; if (r1 !== 2) $display("FAIL b2b_sb_resp got cycle %0d exp 2", r1); else passed++;
    checks++; if (acc !== 3) $display("FAIL b2b_accept got cycle %0d exp 3", acc); else passed++;
    checks++; if (r2 !== 6 || rd !== 32'h000000A5) $display("FAIL b2b_lbu got cycle %0d data %h exp 6 000000a5", r2, rd); else passed++;
  endtask

  task automatic test_random;
    int lat, nrd, nwr, n, bad_bytes; logic err, bad, w, e; logic [31:0] rd, a, wd, exp_rd;
    logic [2:0] f3;
    logic [2:0] f3tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      a = 32'h40 + 4 * i;
      run_req(1'b1, 3'd2, a, wd, lat, err, rd, nrd, nwr, bad);
      for (int j = 0; j < 4; j++) ref_mem[a + j] = wd[8 * j +: 8];
    end
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      f3 = f3tab[$urandom_range(0, 9)];
      a = 32'h40 + $urandom_range(0, 59);
      wd = $urandom;
      n = size_of(f3);
      e = is_err(w, f3, a);
      exp_rd = (e || w) ? 32'd0 : load_model(f3, a);
      run_req(w, f3, a, wd, lat, err, rd, nrd, nwr, bad);
      if (!e && w) for (int j = 0; j < n; j++) ref_mem[a + j] = wd[8 * j +: 8];
      checks++; if (err !== e) $display("FAIL rnd%0d_err got %b exp %b (w=%b f3=%0d a=%h)", i, err, e, w, f3, a); else passed++;
      checks++; if (lat !== (e ? 1 : w ? n + 1 : n + 2)) $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, e ? 1 : w ? n + 1 : n + 2); else passed++;
      checks++; if (rd !== exp_rd) $display("FAIL rnd%0d_rdata got %h exp %h (f3=%0d a=%h)", i, rd, exp_rd, f3, a); else passed++;
      checks++; if (nrd !== ((e || w) ? 0 : n) || nwr !== ((e || !w) ? 0 : n) || bad)
        $display("FAIL rnd%0d_strobes got rd=%0d wr=%0d bad=%b exp %0d/%0d/0", i, nrd, nwr, bad, (e || w) ? 0 : n, (e || !w) ? 0 : n); else passed++;
    end
    bad_bytes = 0;
    for (int j = 'h40; j < 'h80; j++) if (mem[j] !== ref_mem[j]) bad_bytes++;
    checks++; if (bad_bytes !== 0) $display("FAIL rnd_memory got %0d differing bytes exp 0", bad_bytes); else passed++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
